hdmi_xfer_sched: RTL and testbench

//  Sequences all control traffic between the AXI/MicroBlaze side and the HDMI pixel datapath.

---
 rtl/hdmi_xfer_sched.sv | 182 ++++++++++++++++++
 tb/tb_hdmi_xfer_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_xfer_sched.sv
// rtl/hdmi_xfer_sched.sv - control-traffic scheduler for FIR coefficient download and histogram capture
// Purpose: one FSM that serves two four-phase channels toward the pixel datapath:
//   coefficient download from a local shadow RAM, and histogram-frame capture into
//   a local readback buffer. The FSM raises irq once a full frame has been captured.
// Ports:
//   clk, rst                       control clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata      shadow coefficient RAM write port
//   cfg_commit                     pulse, request a full coefficient download
//   hist_arm                       pulse, capture the next histogram frame, clears irq
//   hist_rd_addr/hist_rd_data      readback buffer port, 1-cycle latency
//   busy, coef_done, irq           status
//   fir_coef_write/idx/data/ack    coefficient req/ack channel (ack asynchronous)
//   hist_bin_ready/first/data/saved histogram bin channel (ready asynchronous)
module hdmi_xfer_sched #(
  parameter int NUM_COEF    = 25,
  parameter int COEF_W      = 16,
  parameter int NUM_BINS    = 256,
  parameter int BIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  input  logic              hist_arm,
  input  logic [7:0]        hist_rd_addr,
  output logic [BIN_W-1:0]  hist_rd_data,
  output logic              busy,
  output logic              coef_done,
  output logic              irq,
  output logic              fir_coef_write,
  output logic [4:0]        fir_coef_idx,
  output logic [COEF_W-1:0] fir_coef_data,
  input  logic              fir_coef_ack,
  input  logic              hist_bin_ready,
  input  logic              hist_bin_first,
  input  logic [BIN_W-1:0]  hist_bin_data,
  output logic              hist_bin_saved
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_COEF - 1);
  localparam logic [7:0] LAST_BIN = 8'(NUM_BINS - 1);

  // HACK is the single entry cycle that commits the bin; HSAV holds saved high
  // until the source drops ready.
  typedef enum logic [2:0] {S_IDLE, S_CREQ, S_CREL, S_HACK, S_HSAV, S_HWAIT} state_t;

  state_t r_state, w_next;

  logic [COEF_W-1:0]      r_shadow [NUM_COEF];
  logic [BIN_W-1:0]       r_buf [NUM_BINS];
  logic [SYNC_STAGES-1:0] r_ack_sync, r_rdy_sync;
  logic                   r_commit_p, r_arm_p, r_cap_act, r_irq, r_coef_done;
  logic [4:0]             r_idx;
  logic [7:0]             r_bin_cnt;
  logic [COEF_W-1:0]      r_coef_data;
  logic [BIN_W-1:0]       r_rd_data;

  logic              w_ack_s, w_rdy_s;
  logic              w_take_commit, w_cap_start, w_bin_we, w_hack_exit, w_frame_end, w_coef_last;
  logic              w_load;
  logic [4:0]        w_load_idx;
  logic [7:0]        w_bin_addr;
  logic [COEF_W-1:0] w_load_data;

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
  assign w_rdy_s = r_rdy_sync[SYNC_STAGES-1];

  always_comb begin
    w_next        = r_state;
    w_take_commit = 1'b0;
    w_cap_start   = 1'b0;
    w_bin_we      = 1'b0;
    w_bin_addr    = r_bin_cnt;
    w_hack_exit   = 1'b0;
    w_coef_last   = 1'b0;
    w_load_idx    = r_idx;
    case (r_state)
      S_IDLE: begin
        // A waiting bin always wins so the pixel side only stalls during a download.
        if (w_rdy_s) begin
          w_next = S_HACK;
        end else if (r_commit_p && !r_cap_act) begin
          w_next        = S_CREQ;
          w_take_commit = 1'b1;
          w_load_idx    = 5'd0;
        end
      end
      S_CREQ: if (w_ack_s) w_next = S_CREL;
      S_CREL: begin
        if (!w_ack_s) begin
          if (r_idx == LAST_IDX) begin
            w_coef_last = 1'b1;
            w_next      = S_IDLE;
          end else begin
            w_next     = S_CREQ;
            w_load_idx = r_idx + 5'd1;
          end
        end
      end
      S_HACK: begin
        w_next = S_HSAV;
        if (r_arm_p && hist_bin_first) begin
          w_cap_start = 1'b1;
          w_bin_we    = 1'b1;
          w_bin_addr  = 8'd0;
        end else if (r_cap_act) begin
          w_bin_we = 1'b1;
        end
      end
      S_HSAV: begin
        if (!w_rdy_s) begin
          w_hack_exit = 1'b1;
          w_next      = (r_cap_act && r_bin_cnt != LAST_BIN) ? S_HWAIT : S_IDLE;
        end
      end
      S_HWAIT: if (w_rdy_s) w_next = S_HACK;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_frame_end = w_hack_exit && r_cap_act && (r_bin_cnt == LAST_BIN);
  assign w_load      = (w_next == S_CREQ) && (r_state != S_CREQ);
  // Bypass a same-cycle shadow write so the word latched for the request is the newest one.
  assign w_load_data = (cfg_we && cfg_addr == w_load_idx) ? cfg_wdata : r_shadow[w_load_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack_sync  <= '0;
      r_rdy_sync  <= '0;
      r_commit_p  <= 1'b0;
      r_arm_p     <= 1'b0;
      r_cap_act   <= 1'b0;
      r_irq       <= 1'b0;
      r_coef_done <= 1'b0;
      r_idx       <= 5'd0;
      r_bin_cnt   <= 8'd0;
      r_coef_data <= '0;
    end else begin
      r_state     <= w_next;
      r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], fir_coef_ack};
      r_rdy_sync  <= {r_rdy_sync[SYNC_STAGES-2:0], hist_bin_ready};
      // New request pulses win over the clear so none is lost.
      r_commit_p  <= cfg_commit | (r_commit_p & ~w_take_commit);
      r_arm_p     <= hist_arm | (r_arm_p & ~w_cap_start);
      r_coef_done <= w_coef_last;
      if (w_frame_end)   r_irq <= 1'b1;
      else if (hist_arm) r_irq <= 1'b0;
      if (w_cap_start)      r_cap_act <= 1'b1;
      else if (w_frame_end) r_cap_act <= 1'b0;
      if (w_cap_start)      r_bin_cnt <= 8'd0;
      else if (w_hack_exit) r_bin_cnt <= r_bin_cnt + 8'd1;
      if (w_load) begin
        r_idx       <= w_load_idx;
        r_coef_data <= w_load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && cfg_addr <= LAST_IDX) r_shadow[cfg_addr] <= cfg_wdata;
    if (w_bin_we) r_buf[w_bin_addr] <= hist_bin_data;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_buf[hist_rd_addr];
  end

  assign hist_rd_data   = r_rd_data;
  assign busy           = (r_state != S_IDLE) | r_commit_p | r_arm_p;
  assign coef_done      = r_coef_done;
  assign irq            = r_irq;
  assign fir_coef_write = (r_state == S_CREQ);
  assign fir_coef_idx   = r_idx;
  assign fir_coef_data  = r_coef_data;
  assign hist_bin_saved = (r_state == S_HACK) || (r_state == S_HSAV);

endmodule

// File: tb/tb_hdmi_xfer_sched.sv
// tb/tb_hdmi_xfer_sched.sv - directed bench for hdmi_xfer_sched
module tb_hdmi_xfer_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = 5'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        cfg_commit = 1'b0;
  logic        hist_arm = 1'b0;
  logic [7:0]  hist_rd_addr = 8'd0;
  logic [15:0] hist_rd_data;
  logic        busy, coef_done, irq, fir_coef_write, hist_bin_saved;
  logic [4:0]  fir_coef_idx;
  logic [15:0] fir_coef_data;
  logic        fir_coef_ack = 1'b0;
  logic        hist_bin_ready = 1'b0;
  logic        hist_bin_first = 1'b0;
  logic [15:0] hist_bin_data = 16'd0;

  always #5 clk = ~clk;

  hdmi_xfer_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .hist_arm(hist_arm), .hist_rd_addr(hist_rd_addr),
    .hist_rd_data(hist_rd_data), .busy(busy), .coef_done(coef_done), .irq(irq),
    .fir_coef_write(fir_coef_write), .fir_coef_idx(fir_coef_idx), .fir_coef_data(fir_coef_data),
    .fir_coef_ack(fir_coef_ack), .hist_bin_ready(hist_bin_ready), .hist_bin_first(hist_bin_first),
    .hist_bin_data(hist_bin_data), .hist_bin_saved(hist_bin_saved)
  );

  int total = 0;
  int bad = 0;

  // Edge counters for request, saved and done pulses.
  int   n_wr = 0, n_done = 0, n_sav = 0;
  logic w_d = 1'b0, s_d = 1'b0;
  always @(posedge clk) begin
    w_d <= fir_coef_write;
    s_d <= hist_bin_saved;
    if (fir_coef_write && !w_d) n_wr <= n_wr + 1;
    if (hist_bin_saved && !s_d) n_sav <= n_sav + 1;
    if (coef_done) n_done <= n_done + 1;
  end

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] data;
  } coef_vec_t;
  coef_vec_t cv[25];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t rv[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // which: 0=fir_coef_write 1=hist_bin_saved 2=irq
  task automatic wait_for(input int which, input logic val, input string nm);
    logic s;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s = (which == 0) ? fir_coef_write : (which == 1) ? hist_bin_saved : irq;
      if (s == val) return;
    end
    total++;
    bad++;
    $display("FAIL %s timeout waiting for level %0d", nm, val);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic pulse_arm();
    hist_arm = 1'b1;
    @(negedge clk);
    hist_arm = 1'b0;
  endtask

  // Partner side of the coefficient channel: ack 3 cycles after request, release 3 cycles after drop.
  task automatic coef_xfer(input logic [4:0] ei, input logic [15:0] ed);
    wait_for(0, 1'b1, "coef_req_hi");
    chk("coef_idx", 32'(fir_coef_idx), 32'(ei));
    chk("coef_data", 32'(fir_coef_data), 32'(ed));
    repeat (3) @(negedge clk);
    chk("coef_data_stable", 32'(fir_coef_data), 32'(ed));
    fir_coef_ack = 1'b1;
    wait_for(0, 1'b0, "coef_req_lo");
    repeat (3) @(negedge clk);
    fir_coef_ack = 1'b0;
  endtask

  task automatic run_coef();
    for (int i = 0; i < 25; i++) coef_xfer(cv[i].idx, cv[i].data);
  endtask

  task automatic send_bin(input logic f, input logic [15:0] d);
    hist_bin_first = f;
    hist_bin_data  = d;
    hist_bin_ready = 1'b1;
    wait_for(1, 1'b1, "saved_hi");
    hist_bin_ready = 1'b0;
    wait_for(1, 1'b0, "saved_lo");
    hist_bin_first = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [15:0] e, input string nm);
    hist_rd_addr = a;
    @(negedge clk);
    chk(nm, 32'(hist_rd_data), 32'(e));
  endtask

  int w0, d0, s0;

  initial begin
    for (int i = 0; i < 25; i++) begin
      cv[i].idx  = 5'(i);
      cv[i].data = 16'(16'h100 + i);
    end

    // T1: reset state
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(fir_coef_write), 0);
    chk("rst_saved", 32'(hist_bin_saved), 0);
    chk("rst_idx", 32'(fir_coef_idx), 0);
    chk("rst_done", 32'(coef_done), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_data", 32'(hist_rd_data), 0);
    rst = 1'b0;
    w0 = n_wr;
    fir_coef_ack = 1'b1;
    repeat (5) @(negedge clk);
    fir_coef_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_no_req", 32'(n_wr - w0), 0);
    chk("t1_busy", 32'(busy), 0);

    // T2: full download
    for (int i = 0; i < 25; i++) cfg_write(5'(i), 16'(16'h100 + i));
    cfg_write(5'd27, 16'hDEAD);
    w0 = n_wr; d0 = n_done;
    pulse_commit();
    chk("t2_busy_pending", 32'(busy), 1);
    run_coef();
    repeat (8) @(negedge clk);
    chk("t2_req_count", 32'(n_wr - w0), 25);
    chk("t2_done_count", 32'(n_done - d0), 1);
    chk("t2_busy_after", 32'(busy), 0);

    // T3: armed capture
    pulse_arm();
    chk("t3_busy_armed", 32'(busy), 1);
    for (int i = 0; i < 256; i++) send_bin(i == 0, 16'(i * 3));
    chk("t3_irq", 32'(irq), 1);
    chk("t3_busy_after", 32'(busy), 0);
    for (int k = 0; k < 256; k++) rd_chk(8'(k), 16'(k * 3), "t3_buf");
    hist_rd_addr = 8'd9;
    @(negedge clk);
    hist_rd_addr = 8'd10;
    #1;
    chk("t3_rd_latency_old", 32'(hist_rd_data), 27);
    @(negedge clk);
    chk("t3_rd_latency_new", 32'(hist_rd_data), 30);
    pulse_arm();
    chk("t3_arm_clears_irq", 32'(irq), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t3_rst_busy", 32'(busy), 0);
    rd_chk(8'd7, 16'd21, "t3_buf_survives_rst");

    // T4: unarmed bins are acknowledged but dropped; arm mid-frame waits for next first
    s0 = n_sav;
    for (int i = 0; i < 10; i++) send_bin(i == 0, 16'(16'hAA00 + i));
    chk("t4_saved_count", 32'(n_sav - s0), 10);
    chk("t4_irq", 32'(irq), 0);
    for (int k = 0; k < 10; k++) rd_chk(8'(k), 16'(k * 3), "t4_buf_unchanged");
    for (int i = 0; i < 5; i++) send_bin(i == 0, 16'(16'hAB00 + i));
    pulse_arm();
    for (int i = 5; i < 20; i++) send_bin(1'b0, 16'hBB00);
    chk("t4_mid_irq", 32'(irq), 0);
    rd_chk(8'd5, 16'd15, "t4_mid_buf5");
    rd_chk(8'd1, 16'd3, "t4_mid_buf1");
    for (int i = 0; i < 256; i++) send_bin(i == 0, 16'(16'h5000 + i));
    chk("t4_irq_after_frame", 32'(irq), 1);
    rv[0] = '{8'd0,   16'h5000};
    rv[1] = '{8'd1,   16'h5001};
    rv[2] = '{8'd5,   16'h5005};
    rv[3] = '{8'd128, 16'h5080};
    rv[4] = '{8'd254, 16'h50FE};
    rv[5] = '{8'd255, 16'h50FF};
    for (int i = 0; i < 6; i++) rd_chk(rv[i].addr, rv[i].exp, "t4_buf");

    // T5: commit during capture is held off until the frame completes
    pulse_arm();
    chk("t5_irq_cleared", 32'(irq), 0);
    w0 = n_wr; d0 = n_done;
    send_bin(1'b1, 16'd0);
    pulse_commit();
    for (int i = 1; i < 256; i++) send_bin(1'b0, 16'(i * 7));
    chk("t5_irq", 32'(irq), 1);
    chk("t5_no_req_during_cap", 32'(n_wr - w0), 0);
    cfg_write(5'd20, 16'h7777);
    cv[20].data = 16'h7777;
    run_coef();
    repeat (8) @(negedge clk);
    chk("t5_req_count", 32'(n_wr - w0), 25);
    chk("t5_done_count", 32'(n_done - d0), 1);
    rd_chk(8'd100, 16'd700, "t5_buf100");
    // ready_s and commit_p both present in the same IDLE cycle
    hist_bin_first = 1'b0;
    hist_bin_data  = 16'h1234;
    hist_bin_ready = 1'b1;
    @(negedge clk);
    pulse_commit();
    @(negedge clk);
    chk("t5_bin_first_saved", 32'(hist_bin_saved), 1);
    chk("t5_bin_first_noreq", 32'(fir_coef_write), 0);
    hist_bin_ready = 1'b0;
    wait_for(1, 1'b0, "t5_saved_lo");
    run_coef();
    repeat (8) @(negedge clk);
    chk("t5_busy_end", 32'(busy), 0);

    // T6: reset in the middle of a download
    pulse_commit();
    for (int i = 0; i < 7; i++) coef_xfer(5'(i), 16'(16'h100 + i));
    wait_for(0, 1'b1, "t6_req7");
    chk("t6_idx7", 32'(fir_coef_idx), 7);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_req_dropped", 32'(fir_coef_write), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_commit();
    wait_for(0, 1'b1, "t6_restart");
    chk("t6_restart_idx", 32'(fir_coef_idx), 0);
    chk("t6_restart_data", 32'(fir_coef_data), 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
